// File: rtl/reg_write_ctrl.sv
// Write-port controller for the 32x32 register file: clears registers 1..31
// after reset, then arbitrates two writeback requesters onto the single port.
module reg_write_ctrl #(
    parameter logic [31:0] INIT_VALUE = 32'd0,
    parameter bit          SKIP_INIT  = 1'b0,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic [4:0]       req0_wn,
    input  logic [31:0]      req0_wd,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [4:0]       req1_wn,
    input  logic [31:0]      req1_wd,
    output logic             req1_ready,

    output logic             RegWrite,
    output logic [4:0]       WN,
    output logic [31:0]      WD,
    output logic             init_done,
    output logic [CNT_W-1:0] conflict_cnt,

    output logic             o_dbg_state
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = SKIP_INIT ? ST_RUN : ST_INIT;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [4:0]         r_cnt;
    logic               r_last;
    logic               r_regwrite;
    logic [4:0]         r_wn;
    logic [31:0]        r_wd;
    logic               r_init_done;
    logic [CNT_W-1:0]   r_conflict_cnt;

    logic               w_run;
    logic               w_last_sweep;
    logic               w_both;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_accept;
    logic               w_accept_sel;
    logic [4:0]         w_sel_wn;
    logic [31:0]        w_sel_wd;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: the sweep ends on the edge that issues register 31
    always_comb begin
        w_state_nxt  = r_state;
        w_last_sweep = (r_cnt == 5'd31);
        case (r_state)
            ST_INIT: begin
                if (w_last_sweep) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = RESET_STATE;
            end
        endcase
    end

    // Handshake: a write is accepted on a rising edge where valid && ready.
    // ready is combinational from the valids and r_last, and is only raised
    // in RUN; requesters keep valid/wn/wd stable until accepted and never
    // derive valid from ready. r_last=1 means req1 won the last grant.
    always_comb begin
        w_run        = (r_state == ST_RUN);
        w_both       = req0_valid && req1_valid;
        w_grant0     = req0_valid && (!req1_valid || r_last);
        w_grant1     = req1_valid && (!req0_valid || !r_last);
        req0_ready   = w_run && w_grant0;
        req1_ready   = w_run && w_grant1;
        w_accept     = req0_ready || req1_ready;
        w_accept_sel = req1_ready;
        w_sel_wn     = req0_wn;
        w_sel_wd     = req0_wd;
        if (req1_ready) begin
            w_sel_wn = req1_wn;
            w_sel_wd = req1_wd;
        end
    end

    // Sweep counter and init flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 5'd1;
            r_init_done <= SKIP_INIT;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 5'd1;
            if (w_last_sweep) begin
                r_init_done <= 1'b1;
            end
        end
    end

    // Write-port registers; WN/WD hold when nothing is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite <= 1'b0;
            r_wn       <= 5'd0;
            r_wd       <= 32'd0;
            r_last     <= 1'b1;
        end else if (r_state == ST_INIT) begin
            r_regwrite <= 1'b1;
            r_wn       <= r_cnt;
            r_wd       <= INIT_VALUE;
        end else if (w_accept) begin
            r_regwrite <= (w_sel_wn != 5'd0);
            r_wn       <= w_sel_wn;
            r_wd       <= w_sel_wd;
            r_last     <= w_accept_sel;
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    // Saturating count of RUN cycles with both requesters valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_run && w_both && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign RegWrite     = r_regwrite;
    assign WN           = r_wn;
    assign WD           = r_wd;
    assign init_done    = r_init_done;
    assign conflict_cnt = r_conflict_cnt;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Bench for reg_write_ctrl: directed sweep/arbitration/reset steps plus a
// random phase checked against a rule-level model and a behavioural regfile.
module tb_reg_write_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        v0, v1;
  logic [4:0]  wn0, wn1;
  logic [31:0] wd0, wd1;
  logic        req0_ready, req1_ready;
  logic        RegWrite;
  logic [4:0]  WN;
  logic [31:0] WD;
  logic        init_done;
  logic [15:0] conflict_cnt;
  logic        dbg_state;

  reg_write_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (v0),
    .req0_wn      (wn0),
    .req0_wd      (wd0),
    .req0_ready   (req0_ready),
    .req1_valid   (v1),
    .req1_wn      (wn1),
    .req1_wd      (wd1),
    .req1_ready   (req1_ready),
    .RegWrite     (RegWrite),
    .WN           (WN),
    .WD           (WD),
    .init_done    (init_done),
    .conflict_cnt (conflict_cnt),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- small-counter DUT (no sweep) ----------------
  logic        s_v0, s_v1;
  logic [4:0]  s_wn0, s_wn1;
  logic [31:0] s_wd0, s_wd1;
  logic        s_r0, s_r1, s_rw, s_init, s_dbg;
  logic [4:0]  s_wn;
  logic [31:0] s_wd;
  logic [1:0]  s_cnt;

  reg_write_ctrl #(.INIT_VALUE(32'h5A5A_5A5A), .SKIP_INIT(1'b1), .CNT_W(2)) u_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (s_v0),
    .req0_wn      (s_wn0),
    .req0_wd      (s_wd0),
    .req0_ready   (s_r0),
    .req1_valid   (s_v1),
    .req1_wn      (s_wn1),
    .req1_wd      (s_wd1),
    .req1_ready   (s_r1),
    .RegWrite     (s_rw),
    .WN           (s_wn),
    .WD           (s_wd),
    .init_done    (s_init),
    .conflict_cnt (s_cnt),
    .o_dbg_state  (s_dbg)
  );

  // ---------------- behavioural register file ----------------
  logic        rf_seed;
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (rf_seed) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : (32'hBAD0_0000 | i);
    end else if (RegWrite) begin
      rf[WN] <= WD;
    end
  end

  // ---------------- scoreboard / model ----------------
  int n_pass  = 0;
  int n_total = 0;

  int          m_last;
  int          m_win;
  int          m_cnt;
  logic        m_rw;
  logic [4:0]  m_wn;
  logic [31:0] m_wd;
  logic [31:0] m_rf [32];

  logic        obs_r0, obs_r1, obs_rw;
  logic [4:0]  obs_wn;
  logic [31:0] obs_wd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Winner by the arbitration rules: 0, 1, or -1 for no request
  function automatic int pick(input logic a, input logic b, input int last);
    if (a && b) return (last == 0) ? 1 : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 1;
    m_cnt  = 0;
    m_rw   = 1'b0;
    m_wn   = 5'd0;
    m_wd   = 32'd0;
  endtask

  // One RUN cycle with the current inputs: check at negedge, advance model at posedge
  task automatic run_cycle(input string tag);
    int w;
    @(negedge clk);
    w = pick(v0, v1, m_last);
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    obs_rw = RegWrite;
    obs_wn = WN;
    obs_wd = WD;
    check($sformatf("%s_ready0", tag), 64'(obs_r0), 64'(w == 0));
    check($sformatf("%s_ready1", tag), 64'(obs_r1), 64'(w == 1));
    check($sformatf("%s_regwrite", tag), 64'(obs_rw), 64'(m_rw));
    check($sformatf("%s_wn", tag), 64'(obs_wn), 64'(m_wn));
    check($sformatf("%s_wd", tag), 64'(obs_wd), 64'(m_wd));
    check($sformatf("%s_conflict", tag), 64'(conflict_cnt), 64'(m_cnt));
    @(posedge clk);
    m_win = w;
    if (v0 && v1 && m_cnt < 65535) m_cnt++;
    if (w == 0) begin
      m_rw = (wn0 != 0); m_wn = wn0; m_wd = wd0; m_last = 0;
      if (wn0 != 0) m_rf[wn0] = wd0;
    end else if (w == 1) begin
      m_rw = (wn1 != 0); m_wn = wn1; m_wd = wd1; m_last = 1;
      if (wn1 != 0) m_rf[wn1] = wd1;
    end else begin
      m_rw = 1'b0;
    end
    #1;
  endtask

  // Follows the sweep from the edge after rst_n release up to last_edge
  task automatic sweep_check(input string tag, input int last_edge);
    for (int e = 1; e <= last_edge; e++) begin
      @(posedge clk); #1;
      check($sformatf("%s_rw_e%0d", tag, e), 64'(RegWrite), 64'(1));
      check($sformatf("%s_wn_e%0d", tag, e), 64'(WN), 64'(e));
      check($sformatf("%s_wd_e%0d", tag, e), 64'(WD), 64'(0));
      check($sformatf("%s_done_e%0d", tag, e), 64'(init_done), 64'(e == 31));
    end
    if (last_edge == 31) begin
      @(posedge clk); #1;
      check($sformatf("%s_rw_after", tag), 64'(RegWrite), 64'(0));
      check($sformatf("%s_wn_hold", tag), 64'(WN), 64'(31));
      check($sformatf("%s_state_run", tag), 64'(dbg_state), 64'(1));
      model_reset();
      m_wn = 5'd31;
      for (int i = 1; i < 32; i++) m_rf[i] = 32'd0;
    end
  endtask

  task automatic rf_compare(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_rf%0d", tag, i), 64'(rf[i]), 64'(m_rf[i]));
  endtask

  task automatic check_cleared(input string tag);
    check($sformatf("%s_rw", tag), 64'(RegWrite), 64'(0));
    check($sformatf("%s_wn", tag), 64'(WN), 64'(0));
    check($sformatf("%s_wd", tag), 64'(WD), 64'(0));
    check($sformatf("%s_cnt", tag), 64'(conflict_cnt), 64'(0));
    check($sformatf("%s_done", tag), 64'(init_done), 64'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    v0 = 0; v1 = 0; wn0 = 0; wn1 = 0; wd0 = 0; wd1 = 0;
    s_v0 = 0; s_v1 = 0; s_wn0 = 0; s_wn1 = 0; s_wd0 = 0; s_wd1 = 0;
    rf_seed = 1'b1;
    m_rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) m_rf[i] = 32'hBAD0_0000 | i;
    model_reset();

    // Reset values, with requests pending to show readys stay low in INIT
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    check("reset_state", 64'(dbg_state), 64'(0));
    v0 = 1; v1 = 1; wn0 = 5'd3; wn1 = 5'd4;
    #1;
    check("reset_ready0", 64'(req0_ready), 64'(0));
    check("reset_ready1", 64'(req1_ready), 64'(0));
    check("sat_reset_done", 64'(s_init), 64'(1));
    check("sat_reset_cnt", 64'(s_cnt), 64'(0));
    check("sat_reset_rw", 64'(s_rw), 64'(0));
    v0 = 0; v1 = 0;
    rf_seed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset sweep
    sweep_check("sweep", 31);
    rf_compare("sweep");

    // Conflict right after init: req0 wins first, then strict alternation
    for (int i = 0; i < 4; i++) begin
      v0 = 1; wn0 = 5'd1; wd0 = 32'(10 + i);
      v1 = 1; wn1 = 5'd2; wd1 = 32'(20 + i);
      run_cycle("conflict");
      check($sformatf("conflict_order%0d_r0", i), 64'(obs_r0), 64'(i % 2 == 0));
      check($sformatf("conflict_order%0d_r1", i), 64'(obs_r1), 64'(i % 2 == 1));
    end
    v0 = 0; v1 = 0;
    run_cycle("conflict_drain");
    run_cycle("conflict_drain");
    check("conflict_rf1", 64'(rf[1]), 64'(12));
    check("conflict_rf2", 64'(rf[2]), 64'(23));
    check("conflict_cnt4", 64'(conflict_cnt), 64'(4));

    // Single requester
    v0 = 1; wn0 = 5'd5; wd0 = 32'hDEAD_BEEF;
    run_cycle("single");
    check("single_ready0", 64'(obs_r0), 64'(1));
    v0 = 0;
    run_cycle("single_out");
    check("single_out_rw", 64'(obs_rw), 64'(1));
    check("single_out_wn", 64'(obs_wn), 64'(5));
    check("single_out_wd", 64'(obs_wd), 64'hDEAD_BEEF);
    check("single_rf5", 64'(rf[5]), 64'hDEAD_BEEF);

    // Register 0: handshake completes but no write
    v1 = 1; wn1 = 5'd0; wd1 = 32'd7;
    run_cycle("reg0");
    check("reg0_ready1", 64'(obs_r1), 64'(1));
    v1 = 0;
    run_cycle("reg0_out");
    check("reg0_out_rw", 64'(obs_rw), 64'(0));
    run_cycle("reg0_drain");
    check("reg0_rf0", 64'(rf[0]), 64'(0));

    // Random traffic; each request held until the model says it was granted
    for (int c = 0; c < 300; c++) begin
      if (!v0 && $urandom_range(0, 2) != 0) begin
        v0 = 1; wn0 = 5'($urandom_range(0, 31)); wd0 = $urandom;
      end
      if (!v1 && $urandom_range(0, 2) != 0) begin
        v1 = 1; wn1 = 5'($urandom_range(0, 31)); wd1 = $urandom;
      end
      run_cycle("rand");
      if (m_win == 0) v0 = 0;
      if (m_win == 1) v1 = 0;
    end
    v0 = 0; v1 = 0;
    run_cycle("rand_drain");
    run_cycle("rand_drain");
    rf_compare("rand");

    // Reset mid-operation, then mid-sweep
    rst_n = 1'b0;
    #1;
    check_cleared("async_clear");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check("partial", 10);
    rst_n = 1'b0;
    #1;
    check_cleared("midsweep_clear");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_cleared($sformatf("midsweep_hold%0d", k));
    end
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check("resweep", 31);
    rf_compare("resweep");

    // Pointer is reset too: first conflict after reset goes to req0
    v0 = 1; wn0 = 5'd7; wd0 = 32'h1111;
    v1 = 1; wn1 = 5'd8; wd1 = 32'h2222;
    run_cycle("post_reset");
    check("post_reset_r0_first", 64'(obs_r0), 64'(1));
    v0 = 0;
    run_cycle("post_reset2");
    check("post_reset_r1_second", 64'(obs_r1), 64'(1));
    v1 = 0;
    run_cycle("post_reset_drain");
    run_cycle("post_reset_drain");
    rf_compare("post_reset");

    // Saturation on the 2-bit counter instance, grants keep alternating
    s_v0 = 1; s_wn0 = 5'd3;
    s_v1 = 1; s_wn1 = 5'd4;
    for (int k = 0; k < 6; k++) begin
      s_wd0 = 32'(100 + k);
      s_wd1 = 32'(200 + k);
      @(negedge clk);
      check($sformatf("sat_r0_%0d", k), 64'(s_r0), 64'(k % 2 == 0));
      check($sformatf("sat_r1_%0d", k), 64'(s_r1), 64'(k % 2 == 1));
      check($sformatf("sat_cnt_%0d", k), 64'(s_cnt), 64'((k < 3) ? k : 3));
      @(posedge clk); #1;
      check($sformatf("sat_rw_%0d", k), 64'(s_rw), 64'(1));
      check($sformatf("sat_wn_%0d", k), 64'(s_wn), 64'((k % 2 == 0) ? 3 : 4));
      check($sformatf("sat_wd_%0d", k), 64'(s_wd), 64'((k % 2 == 0) ? 100 + k : 200 + k));
    end
    s_v0 = 0; s_v1 = 0;
    @(negedge clk);
    check("sat_cnt_final", 64'(s_cnt), 64'(3));
    check("sat_done", 64'(s_init), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_write_ctrl.md
# reg_write_ctrl

Write-port controller for the 32x32 register file. After reset it clears registers 1..31 by sequencing the register file's single write port. It then shares that port between two writeback requesters, such as the ALU result path and the load-data path, using a valid/ready handshake and round-robin arbitration. It drives the register file's `RegWrite`, `WN` and `WD` inputs from registered outputs.

## Interface
- `INIT_VALUE`, default 32'd0: data written to every register during the post-reset sweep.
- `SKIP_INIT`, default 0: when 1, the sweep is omitted and the block comes out of reset in RUN.
- `CNT_W`, default 16: width of the conflict counter.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a write pending.
- `req0_wn` in 5: requester 0 destination register.
- `req0_wd` in 32: requester 0 write data.
- `req0_ready` out 1: requester 0 write accepted this cycle.
- `req1_valid`, `req1_wn`, `req1_wd`, `req1_ready`: same as requester 0, for requester 1.
- `RegWrite` out 1: write enable to the register file (registered).
- `WN` out 5: write register number (registered).
- `WD` out 32: write data (registered).
- `init_done` out 1: high once the sweep has been issued.
- `conflict_cnt` out CNT_W: saturating count of cycles in which both requesters were valid in RUN.

## Operation
- States are INIT and RUN. On reset the state is INIT, or RUN if SKIP_INIT=1. The sweep counter resets to 1.
- INIT:
  - On each rising edge, load RegWrite=1, WN=cnt, WD=INIT_VALUE, then increment cnt.
  - On the edge where cnt=31, go to RUN and set init_done=1.
  - Both readys are held 0 throughout INIT.
- RUN, grant logic (combinational from the valids and the pointer `last`):
  - Only req0 valid: req0 is granted.
  - Only req1 valid: req1 is granted.
  - Both valid: the requester other than `last` is granted.
  - `reqN_ready` = RUN && grantN. At most one ready is high per cycle.
- RUN, on an accept (valid && ready at a rising edge):
  - Load WN and WD from the granted requester.
  - Set RegWrite=1, unless the requester's wn is 0. A write to register 0 is accepted, handshake completes, but RegWrite=0.
  - Set `last` to the granted requester.
- RUN, with no accept: load RegWrite=0. WN and WD hold their previous values.
- `last` resets to 1, so req0 wins the first conflict.
- Requesters must not make valid depend on ready. Once valid is asserted, wn and wd are held stable until accepted.
- `conflict_cnt` increments on each RUN edge where both valids are high and saturates at all-ones. It does not count during INIT.
- Reset mid-operation (rst_n low at any time):
  - All outputs clear immediately.
  - Any accepted-but-unwritten request is lost.
  - The sweep restarts from register 1.

## Timing
- Reset values:
  - RegWrite=0, WN=0, WD=0, conflict_cnt=0.
  - init_done=0, or 1 if SKIP_INIT.
  - req0_ready=0, req1_ready=0.
- Sweep:
  - rst_n deasserts before edge 1.
  - Edges 1..31 present WN=1..31 with RegWrite=1.
  - The register file commits each write one edge later, on edges 2..32.
  - init_done=1 after edge 31, and readys may go high in that same cycle.
- Write latency:
  - A request accepted at edge N appears on RegWrite/WN/WD during cycle N+1.
  - The register file commits it at edge N+1.
- Throughput: one accepted write per cycle, back-to-back, with no bubble.
- Fairness: under continuous conflict, grants alternate strictly req0, req1, req0, ...
- A new value on WN/WD never overlaps the register file's sampling of the previous value, because the outputs change only on the same edge at which the previous value is sampled.

## Test plan
- Reset sweep: release rst_n and hold both valids at 0. Required: RegWrite=1 for exactly 31 cycles with WN=1,2,...,31 and WD=0, then RegWrite=0. init_done rises after edge 31. Reading every register afterwards returns 0.
- Single requester: after init, req0 writes (wn=5, wd=32'hDEADBEEF) for one cycle. Required: req0_ready=1 that cycle; next cycle RegWrite=1, WN=5, WD=32'hDEADBEEF; register 5 reads 32'hDEADBEEF afterwards.
- Conflict: both requesters valid for 4 cycles, req0 (wn=1, wd=10+i) and req1 (wn=2, wd=20+i). Required:
  - Grant order is req0, req1, req0, req1.
  - Register 1 ends at 12 and register 2 ends at 23.
  - conflict_cnt=4.
- Register 0: req1 writes (wn=0, wd=7). Required: req1_ready=1, RegWrite stays 0, and register 0 still reads 0.
- Reset mid-sweep: assert rst_n low after edge 10, hold it for 2 cycles, then release. Required: outputs are 0 while reset is low, and the sweep restarts at WN=1 and runs the full 31 writes.
- Saturation, with CNT_W=2: hold both valids for 6 cycles. Required: conflict_cnt reads 1, 2, 3, 3, 3, 3, and grants keep alternating throughout.
